// File: rtl/tex_req_arb_pkg.sv
// Shared texture-path constants: payload widths for the tex request/response
// buses and the source-ID width helper.
package tex_req_arb_pkg;

  localparam int NUM_REQS          = 4;
  localparam int TEX_FILTER_BITS   = 1;
  localparam int TEX_LGSTRIDE_BITS = 3;
  localparam int TEX_ADDRW         = 128;  // four 32-bit quad texel addresses per lane
  localparam int TEX_BASEADDRW     = 64;
  localparam int TEX_DATAW         = 128;  // four 32-bit texels per lane
  localparam int REQ_INFOW         = 44;

  // tmask + filter + lgstride + addr per lane, then baseaddr and info
  localparam int TEX_REQ_DATAW =
    NUM_REQS * (1 + TEX_FILTER_BITS + TEX_LGSTRIDE_BITS + TEX_ADDRW) + TEX_BASEADDRW + REQ_INFOW;
  localparam int TEX_RSP_DATAW = NUM_REQS * (1 + TEX_DATAW) + REQ_INFOW;

  function automatic int src_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tex_rr_arbiter.sv
// Round-robin arbiter with grant lock: a winner that was offered but not
// accepted keeps the grant until it fires.
module tex_rr_arbiter
  import tex_req_arb_pkg::*;
#(
  parameter  int NUM_SRCS = 4,
  localparam int SRC_BITS = src_bits(NUM_SRCS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_SRCS-1:0] valid_i,
  input  logic                hold_i,
  input  logic                fire_i,
  output logic [SRC_BITS-1:0] grant_idx_o,
  output logic [NUM_SRCS-1:0] grant_oh_o,
  output logic                grant_valid_o
);

  logic [SRC_BITS-1:0]   rr_ptr_q, rr_ptr_d;
  logic [SRC_BITS-1:0]   lock_id_q, lock_id_d;
  logic                  lock_q, lock_d;
  logic [SRC_BITS-1:0]   rr_off, rr_idx;
  logic                  rr_found;
  logic [2*NUM_SRCS-1:0] valid_dbl;
  logic [NUM_SRCS-1:0]   valid_rot;
  logic [SRC_BITS:0]     rr_sum;

  // Rotate so that bit 0 is the source at rr_ptr, then take the first set bit.
  always_comb begin
    valid_dbl = {valid_i, valid_i} >> rr_ptr_q;
    valid_rot = valid_dbl[NUM_SRCS-1:0];
    rr_off    = '0;
    rr_found  = 1'b0;
    for (int i = 0; i < NUM_SRCS; i++) begin
      if (!rr_found && valid_rot[i]) begin
        rr_found = 1'b1;
        rr_off   = SRC_BITS'(i);
      end
    end
    rr_sum = {1'b0, rr_ptr_q} + {1'b0, rr_off};
    if (rr_sum >= (SRC_BITS+1)'(NUM_SRCS))
      rr_sum = rr_sum - (SRC_BITS+1)'(NUM_SRCS);
    rr_idx = rr_sum[SRC_BITS-1:0];
  end

  assign grant_idx_o   = lock_q ? lock_id_q : rr_idx;
  assign grant_valid_o = lock_q ? valid_i[lock_id_q] : rr_found;
  assign grant_oh_o    = grant_valid_o ? (NUM_SRCS'(1) << grant_idx_o) : '0;

  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    if (fire_i) begin
      lock_d   = 1'b0;
      rr_ptr_d = (grant_idx_o == SRC_BITS'(NUM_SRCS-1)) ? '0 : grant_idx_o + 1'b1;
    end else if (hold_i) begin
      lock_d    = 1'b1;
      lock_id_d = grant_idx_o;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q  <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
    end
  end

endmodule

// File: rtl/tex_req_arb.sv
// Shares one in-order texture memory unit among NUM_SRCS request sources; an
// order FIFO of source IDs steers each response back to its requester.
module tex_req_arb
  import tex_req_arb_pkg::*;
#(
  parameter  int NUM_SRCS    = 4,
  parameter  int REQ_DATAW   = TEX_REQ_DATAW,
  parameter  int RSP_DATAW   = TEX_RSP_DATAW,
  parameter  int MAX_PENDING = 8,
  localparam int SRC_BITS    = src_bits(NUM_SRCS),
  localparam int CNTW        = $clog2(MAX_PENDING+1)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_SRCS-1:0]                src_req_valid,
  input  logic [NUM_SRCS-1:0][REQ_DATAW-1:0] src_req_data,
  output logic [NUM_SRCS-1:0]                src_req_ready,
  output logic                               mem_req_valid,
  output logic [REQ_DATAW-1:0]               mem_req_data,
  input  logic                               mem_req_ready,
  input  logic                               mem_rsp_valid,
  input  logic [RSP_DATAW-1:0]               mem_rsp_data,
  output logic                               mem_rsp_ready,
  output logic [NUM_SRCS-1:0]                src_rsp_valid,
  output logic [RSP_DATAW-1:0]               src_rsp_data,
  input  logic [NUM_SRCS-1:0]                src_rsp_ready,
  output logic [CNTW-1:0]                    pending_count
);

  localparam int PTRW = $clog2(MAX_PENDING);

  logic [SRC_BITS-1:0] grant_idx;
  logic [NUM_SRCS-1:0] grant_oh;
  logic                grant_valid;
  logic                req_offer, req_fire, rsp_fire, rsp_en;

  logic [SRC_BITS-1:0] ofifo_mem [MAX_PENDING];
  logic [PTRW-1:0]     wptr_q, rptr_q;
  logic [CNTW-1:0]     count_q, count_d;
  logic                ofifo_full, ofifo_empty;
  logic [SRC_BITS-1:0] head;

  tex_rr_arbiter #(.NUM_SRCS(NUM_SRCS)) u_arb (
    .clk           (clk),
    .reset         (reset),
    .valid_i       (src_req_valid),
    .hold_i        (req_offer & ~mem_req_ready),
    .fire_i        (req_fire),
    .grant_idx_o   (grant_idx),
    .grant_oh_o    (grant_oh),
    .grant_valid_o (grant_valid)
  );

  // A full order FIFO blocks the request even if a response pops this cycle.
  assign ofifo_full  = (count_q == CNTW'(MAX_PENDING));
  assign ofifo_empty = (count_q == '0);

  assign req_offer     = ~reset & grant_valid & ~ofifo_full;
  assign req_fire      = req_offer & mem_req_ready;
  assign mem_req_valid = req_offer;
  assign mem_req_data  = src_req_data[grant_idx];
  assign src_req_ready = grant_oh & {NUM_SRCS{req_fire}};

  assign head          = ofifo_mem[rptr_q];
  assign rsp_en        = ~reset & ~ofifo_empty;
  assign mem_rsp_ready = rsp_en & src_rsp_ready[head];
  assign src_rsp_valid = (NUM_SRCS'(1) << head) & {NUM_SRCS{rsp_en & mem_rsp_valid}};
  assign src_rsp_data  = mem_rsp_data;
  assign rsp_fire      = mem_rsp_valid & mem_rsp_ready;

  assign pending_count = count_q;

  always_comb begin
    count_d = count_q;
    case ({req_fire, rsp_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (req_fire) ofifo_mem[wptr_q] <= grant_idx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (req_fire) wptr_q <= wptr_q + 1'b1;
      if (rsp_fire) rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  a_rsp_without_req: assert property (@(posedge clk) disable iff (reset)
    !(mem_rsp_valid && ofifo_empty));
  a_count_bound: assert property (@(posedge clk) disable iff (reset)
    count_q <= CNTW'(MAX_PENDING));

endmodule

// File: tb/tb_tex_req_arb.sv
// Bench for tex_req_arb: vector table for arbitration/lock/full, then
// hand sequences for response routing, simultaneous fire and reset.
module tb_tex_req_arb;
  import tex_req_arb_pkg::*;

  localparam int N   = 4;
  localparam int RQW = TEX_REQ_DATAW;
  localparam int RSW = TEX_RSP_DATAW;
  localparam int MP  = 8;
  localparam int CW  = $clog2(MP+1);

  logic                   clk = 1'b0;
  logic                   reset;
  logic [N-1:0]           src_req_valid;
  logic [N-1:0][RQW-1:0]  src_req_data;
  logic [N-1:0]           src_req_ready;
  logic                   mem_req_valid;
  logic [RQW-1:0]         mem_req_data;
  logic                   mem_req_ready;
  logic                   mem_rsp_valid;
  logic [RSW-1:0]         mem_rsp_data;
  logic                   mem_rsp_ready;
  logic [N-1:0]           src_rsp_valid;
  logic [RSW-1:0]         src_rsp_data;
  logic [N-1:0]           src_rsp_ready;
  logic [CW-1:0]          pending_count;

  tex_req_arb #(.NUM_SRCS(N), .REQ_DATAW(RQW), .RSP_DATAW(RSW), .MAX_PENDING(MP)) dut (
    .clk(clk), .reset(reset),
    .src_req_valid(src_req_valid), .src_req_data(src_req_data), .src_req_ready(src_req_ready),
    .mem_req_valid(mem_req_valid), .mem_req_data(mem_req_data), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_ready(mem_rsp_ready),
    .src_rsp_valid(src_rsp_valid), .src_rsp_data(src_rsp_data), .src_rsp_ready(src_rsp_ready),
    .pending_count(pending_count)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int sb[$];

  typedef struct {
    logic       rst;
    logic [3:0] vld;
    logic       rdy;
    logic [3:0] e_rdy;
    logic       e_mv;
    int         e_src;
    int         e_pend;
  } vec_t;
  vec_t tv[14];

  function automatic logic [RQW-1:0] pay(input int s);
    logic [RQW-1:0] p;
    p = '0;
    p[31:0]        = 32'hC0DE_0000 + 32'(s);
    p[RQW-1 -: 32] = 32'hBEEF_0000 + 32'(s * 16);
    return p;
  endfunction

  function automatic logic [3:0] oh(input int s);
    return 4'd1 << s;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One accepted response to the head source, checked against the scoreboard.
  task automatic rsp_one(input string nm);
    int h;
    h = sb.pop_front();
    src_req_valid = '0;
    src_rsp_ready = '1;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = '0;
    mem_rsp_data[31:0]        = $urandom;
    mem_rsp_data[RSW-1 -: 32] = $urandom;
    #2;
    chk({nm, " rsp_vld"},  src_rsp_valid, oh(h));
    chk({nm, " rsp_rdy"},  mem_rsp_ready, 1);
    chk({nm, " rsp_data"}, src_rsp_data == mem_rsp_data, 1);
    tick();
    mem_rsp_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    // rst, vld, rdy, expected src_req_ready, mem_req_valid, winner, pending
    tv[0]  = '{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 0, 0};
    tv[1]  = '{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 2, 0};
    tv[2]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 0, 1};
    tv[3]  = '{1'b0, 4'b1001, 1'b1, 4'b1000, 1'b1, 3, 1};
    tv[4]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 0, 2};
    tv[5]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 1, 3};
    tv[6]  = '{1'b0, 4'b0010, 1'b0, 4'b0000, 1'b1, 1, 4};
    tv[7]  = '{1'b0, 4'b0011, 1'b0, 4'b0000, 1'b1, 1, 4};
    tv[8]  = '{1'b0, 4'b0011, 1'b0, 4'b0000, 1'b1, 1, 4};
    tv[9]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 1, 4};
    tv[10] = '{1'b0, 4'b1101, 1'b1, 4'b0100, 1'b1, 2, 5};
    tv[11] = '{1'b0, 4'b1001, 1'b1, 4'b1000, 1'b1, 3, 6};
    tv[12] = '{1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, 0, 7};
    tv[13] = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0, 0, 8};

    reset = 1'b1;
    src_req_valid = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    src_rsp_ready = '1;
    for (int i = 0; i < N; i++) src_req_data[i] = pay(i);
    repeat (2) @(posedge clk);
    #1;

    for (int k = 0; k < 14; k++) begin
      reset         = tv[k].rst;
      src_req_valid = tv[k].vld;
      mem_req_ready = tv[k].rdy;
      #2;
      chk($sformatf("v%0d req_rdy", k), src_req_ready, tv[k].e_rdy);
      chk($sformatf("v%0d mem_vld", k), mem_req_valid, tv[k].e_mv);
      chk($sformatf("v%0d pending", k), pending_count, tv[k].e_pend);
      if (tv[k].e_mv)
        chk($sformatf("v%0d mem_data", k), mem_req_data == pay(tv[k].e_src), 1);
      if (tv[k].rst) sb.delete();
      else if (tv[k].rdy && tv[k].e_rdy != 0) sb.push_back(tv[k].e_src);
      tick();
    end

    // Full: a popping response does not unblock the request in the same cycle.
    src_req_valid = 4'b1111;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = '0;
    mem_rsp_data[63:0] = 64'h1234_5678_9ABC_DEF0;
    #2;
    chk("full mem_vld", mem_req_valid, 0);
    chk("full req_rdy", src_req_ready, 0);
    chk("full rsp_vld", src_rsp_valid, oh(sb[0]));
    chk("full rsp_rdy", mem_rsp_ready, 1);
    chk("full rsp_data", src_rsp_data[63:0], 64'h1234_5678_9ABC_DEF0);
    void'(sb.pop_front());
    tick();
    mem_rsp_valid = 1'b0;

    // Slot freed: request offered again; hold it with ready low (locks src1).
    src_req_valid = 4'b0010;
    mem_req_ready = 1'b0;
    #2;
    chk("freed mem_vld", mem_req_valid, 1);
    chk("freed req_rdy", src_req_ready, 0);
    chk("freed pending", pending_count, 7);
    chk("freed mem_data", mem_req_data == pay(1), 1);
    tick();

    rsp_one("drain0");
    rsp_one("drain1");

    // Head source not ready: no handshake, no pop.
    src_req_valid = '0;
    mem_rsp_valid = 1'b1;
    src_rsp_ready = ~oh(sb[0]);
    #2;
    chk("bp rsp_rdy", mem_rsp_ready, 0);
    chk("bp rsp_vld", src_rsp_valid, oh(sb[0]));
    chk("bp pending", pending_count, 5);
    tick();

    // Simultaneous request fire and response fire at 5 pending.
    src_rsp_ready = '1;
    src_req_valid = 4'b0010;
    mem_req_ready = 1'b1;
    #2;
    chk("sim req_rdy", src_req_ready, 4'b0010);
    chk("sim rsp_rdy", mem_rsp_ready, 1);
    chk("sim rsp_vld", src_rsp_valid, oh(sb[0]));
    chk("sim pending", pending_count, 5);
    void'(sb.pop_front());
    sb.push_back(1);
    tick();
    mem_rsp_valid = 1'b0;
    src_req_valid = '0;
    #2;
    chk("sim after pending", pending_count, 5);
    tick();
    rsp_one("drain2");
    #2;
    chk("pre-rst pending", pending_count, 4);

    // Reset with requests in flight: everything forced low, state cleared.
    reset         = 1'b1;
    src_req_valid = 4'b1111;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b1;
    #1;
    chk("rst mem_vld", mem_req_valid, 0);
    chk("rst req_rdy", src_req_ready, 0);
    chk("rst rsp_vld", src_rsp_valid, 0);
    chk("rst rsp_rdy", mem_rsp_ready, 0);
    tick();
    sb.delete();
    reset         = 1'b0;
    mem_rsp_valid = 1'b0;
    src_req_valid = 4'b0110;
    mem_req_ready = 1'b0;
    #2;
    chk("post-rst pending", pending_count, 0);
    chk("post-rst mem_vld", mem_req_valid, 1);
    chk("post-rst mem_data", mem_req_data == pay(1), 1);
    chk("post-rst rsp_rdy", mem_rsp_ready, 0);
    chk("post-rst rsp_vld", src_rsp_valid, 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/tex_req_arb.md
Name: tex_req_arb

Overview:
- Shares one texture memory unit (quad-texel fetch datapath, in-order response) among NUM_SRCS texture request sources, e.g. per-issue-slot tex units.
- Round-robin arbitration on the request side; an order FIFO of source IDs routes each in-order response back to its originator.
- Sits between the tex request sources and the texture memory unit's req/rsp handshake ports.

Parameters:
- NUM_SRCS, 4, number of requesters; must be >= 2.
- REQ_DATAW, 640, packed request payload width (tmask, filter, lgstride, baseaddr, addr, info); opaque to this block.
- RSP_DATAW, 560, packed response payload width (tmask, data, info); opaque.
- MAX_PENDING, 8, max requests in flight in the memory unit; power of 2.
- SRC_BITS, $clog2(NUM_SRCS), derived source-ID width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- src_req_valid  in  NUM_SRCS  per-source request valid
- src_req_data  in  NUM_SRCS*REQ_DATAW  per-source payload
- src_req_ready  out  NUM_SRCS  per-source accept
- mem_req_valid  out  1  request to memory unit
- mem_req_data  out  REQ_DATAW  selected payload
- mem_req_ready  in  1  memory unit accept
- mem_rsp_valid  in  1  response from memory unit
- mem_rsp_data  in  RSP_DATAW  response payload
- mem_rsp_ready  out  1  response accept
- src_rsp_valid  out  NUM_SRCS  one-hot response valid
- src_rsp_data  out  RSP_DATAW  response payload, broadcast to all sources
- src_rsp_ready  in  NUM_SRCS  per-source response accept
- pending_count  out  $clog2(MAX_PENDING+1)  requests in flight

Behaviour:
- Sources hold valid and data stable until ready; the arbiter relies on this.
- Arbitration:
  - Combinational round-robin priority starting at rr_ptr; winner = first valid source at or after rr_ptr, mod NUM_SRCS.
  - mem_req_valid = any valid && ~ofifo_full.
  - mem_req_data = winner payload.
  - src_req_ready[w] = mem_req_ready && ~ofifo_full for the winner only; 0 for all others.
- Grant lock: if mem_req_valid && ~mem_req_ready, lock the winner ID. While locked, the grant stays on that source even if a higher-priority source becomes valid. Unlock on fire.
- On request fire (from source w): rr_ptr <= (w+1) mod NUM_SRCS, registered, effective next cycle. No fire leaves rr_ptr unchanged.
- Order FIFO (depth MAX_PENDING, width SRC_BITS):
  - Push winner ID on request fire.
  - Pop on response fire.
  - Push is blocked when full, even if a pop occurs the same cycle.
  - Simultaneous push and pop when non-empty: occupancy unchanged, both operations take effect.
- Response routing, zero-cycle combinational:
  - h = FIFO head.
  - src_rsp_valid = onehot(h) & {NUM_SRCS{mem_rsp_valid && ~ofifo_empty}}.
  - mem_rsp_ready = ~ofifo_empty && src_rsp_ready[h].
  - src_rsp_data = mem_rsp_data.
- mem_rsp_valid with the FIFO empty is a protocol error: simulation assertion fires, mem_rsp_ready = 0.
- pending_count:
  - +1 on request fire only, -1 on response fire only; unchanged on both or neither.
  - Never exceeds MAX_PENDING; wraps are impossible by construction (assert).
- Latency: 0 cycles request pass-through and 0 cycles response pass-through. No added pipeline stage.
- Reset:
  - rr_ptr=0, lock cleared, FIFO empty, pending_count=0.
  - Consequently mem_req_valid=0, src_req_ready=0, src_rsp_valid=0, mem_rsp_ready=0 are all forced low while reset is asserted.
  - Reset mid-operation discards in-flight IDs; the memory unit must be reset on the same cycle.

Decomposition:
- Shared tex package: SRC_BITS helper, and request/response payload width constants (REQ_DATAW/RSP_DATAW derived from NUM_REQS, TEX_FILTER_BITS, TEX_LGSTRIDE_BITS, REQ_INFOW).
- Sub-module: tex_rr_arbiter (NUM_SRCS-wide round-robin with lock, outputs grant index and one-hot).
- Order FIFO uses the existing generic fifo queue (OUT_REG=0).

Test Plan:
- Single source 2 valid, mem_req_ready=1 -> mem_req_data = src2 payload same cycle; pending_count 0→1; rr_ptr=3 next cycle.
- All 4 sources valid continuously, ready=1 -> grant order 0,1,2,3,0; each source receives exactly 1 of every 4 fires.
- Src1 granted with mem_req_ready=0 for 3 cycles while src0 asserts -> grant held on src1; src1 fires on cycle 4; src0 granted only after src2/src3 if they are valid.
- Issue 8 requests (IDs 3,1,0,2,3,1,0,2) with no responses -> 9th request stalled (mem_req_valid=0, all src_req_ready=0), pending_count=8. One response then returns to src3 and frees a slot the cycle after.
- Response with src_rsp_ready[head]=0 -> mem_rsp_ready=0 and FIFO not popped. Same-cycle request fire and response fire at count 5 -> count stays 5.
- Assert reset with 4 pending -> next cycle pending_count=0, all valids low, rr_ptr=0; the first post-reset grant goes to the lowest-index valid source.
